// File: rtl/aes_pkg.sv
// Shared AES constants, control-state encodings and GF(2^8) helpers for the
// inverse-cipher datapath.
package aes_pkg;

  // Key-length codes as presented on the keylen input.
  localparam logic AES_128_BIT_KEY = 1'b0;
  localparam logic AES_256_BIT_KEY = 1'b1;

  // Round counts Nr.
  localparam logic [3:0] AES128_ROUNDS = 4'ha;
  localparam logic [3:0] AES256_ROUNDS = 4'he;

  // Control FSM encodings.
  localparam logic [1:0] CTRL_IDLE = 2'd0;
  localparam logic [1:0] CTRL_INIT = 2'd1;
  localparam logic [1:0] CTRL_SBOX = 2'd2;
  localparam logic [1:0] CTRL_MAIN = 2'd3;

  function automatic logic [3:0] num_rounds(input logic kl);
    return (kl == AES_256_BIT_KEY) ? AES256_ROUNDS : AES128_ROUNDS;
  endfunction

  function automatic logic [7:0] gm2(input logic [7:0] op);
    return {op[6:0], 1'b0} ^ (op[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm4(input logic [7:0] op);
    return gm2(gm2(op));
  endfunction

  function automatic logic [7:0] gm8(input logic [7:0] op);
    return gm2(gm4(op));
  endfunction

  function automatic logic [7:0] gm09(input logic [7:0] op);
    return gm8(op) ^ op;
  endfunction

  function automatic logic [7:0] gm11(input logic [7:0] op);
    return gm8(op) ^ gm2(op) ^ op;
  endfunction

  function automatic logic [7:0] gm13(input logic [7:0] op);
    return gm8(op) ^ gm4(op) ^ op;
  endfunction

  function automatic logic [7:0] gm14(input logic [7:0] op);
    return gm8(op) ^ gm4(op) ^ gm2(op);
  endfunction

  // InvMixColumns on one column; byte 0 (row 0) is the most significant.
  function automatic logic [31:0] inv_mixw(input logic [31:0] w);
    logic [7:0] b0, b1, b2, b3;
    logic [7:0] mb0, mb1, mb2, mb3;
    b0  = w[31:24];
    b1  = w[23:16];
    b2  = w[15:8];
    b3  = w[7:0];
    mb0 = gm14(b0) ^ gm11(b1) ^ gm13(b2) ^ gm09(b3);
    mb1 = gm09(b0) ^ gm14(b1) ^ gm11(b2) ^ gm13(b3);
    mb2 = gm13(b0) ^ gm09(b1) ^ gm14(b2) ^ gm11(b3);
    mb3 = gm11(b0) ^ gm13(b1) ^ gm09(b2) ^ gm14(b3);
    return {mb0, mb1, mb2, mb3};
  endfunction

  // InvShiftRows on {w0,w1,w2,w3}: row r rotates right by r columns.
  function automatic logic [127:0] inv_shiftrows(input logic [127:0] data);
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] ws0, ws1, ws2, ws3;
    w0  = data[127:96];
    w1  = data[95:64];
    w2  = data[63:32];
    w3  = data[31:0];
    ws0 = {w0[31:24], w3[23:16], w2[15:8], w1[7:0]};
    ws1 = {w1[31:24], w0[23:16], w3[15:8], w2[7:0]};
    ws2 = {w2[31:24], w1[23:16], w0[15:8], w3[7:0]};
    ws3 = {w3[31:24], w2[23:16], w1[15:8], w0[7:0]};
    return {ws0, ws1, ws2, ws3};
  endfunction

endpackage : aes_pkg

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box applied to all four bytes of a word.
module aes_inv_sbox (
  input  logic [31:0] sboxw,
  output logic [31:0] new_sboxw
);

  localparam logic [7:0] INV_SBOX [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Four independent byte lookups.
  always_comb begin
    new_sboxw = {INV_SBOX[sboxw[31:24]], INV_SBOX[sboxw[23:16]],
                 INV_SBOX[sboxw[15:8]],  INV_SBOX[sboxw[7:0]]};
  end

endmodule : aes_inv_sbox

// File: rtl/aes_decipher_round.sv
// Iterative AES inverse cipher: one block, one S-box word per cycle, one
// InvShiftRows/AddRoundKey/InvMixColumns cycle per round.
module aes_decipher_round
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         next,
  input  logic         keylen,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready
);

  logic [1:0]   state;
  logic [3:0]   round_ctr;
  logic [1:0]   sword_ctr;
  logic         keylen_reg;
  logic         ready_reg;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  sbox_in;
  logic [31:0]  sbox_out;
  logic [127:0] added;
  logic [127:0] round_out;

  assign round     = round_ctr;
  assign new_block = {w0, w1, w2, w3};
  assign ready     = ready_reg;

  // Route the word selected by the sword counter to the shared S-box.
  always_comb begin
    sbox_in = w0;
    case (sword_ctr)
      2'd0: sbox_in = w0;
      2'd1: sbox_in = w1;
      2'd2: sbox_in = w2;
      2'd3: sbox_in = w3;
      default: sbox_in = w0;
    endcase
  end

  aes_inv_sbox u_inv_sbox (
    .sboxw     (sbox_in),
    .new_sboxw (sbox_out)
  );

  // Round update; InvSubBytes was already done on unshifted words, which is
  // equivalent because the S-box is bytewise.
  always_comb begin
    added     = inv_shiftrows({w0, w1, w2, w3}) ^ round_key;
    round_out = added;
    if (round_ctr != 4'd0) begin
      round_out = {inv_mixw(added[127:96]), inv_mixw(added[95:64]),
                   inv_mixw(added[63:32]),  inv_mixw(added[31:0])};
    end
  end

  // Control FSM, counters and state word registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= CTRL_IDLE;
      round_ctr  <= '0;
      sword_ctr  <= '0;
      keylen_reg <= AES_128_BIT_KEY;
      ready_reg  <= 1'b1;
      w0         <= '0;
      w1         <= '0;
      w2         <= '0;
      w3         <= '0;
    end else begin
      case (state)
        CTRL_IDLE: begin
          if (next) begin
            ready_reg  <= 1'b0;
            keylen_reg <= keylen;
            round_ctr  <= num_rounds(keylen);
            state      <= CTRL_INIT;
          end
        end
        CTRL_INIT: begin
          {w0, w1, w2, w3} <= block ^ round_key;
          round_ctr        <= num_rounds(keylen_reg) - 4'd1;
          sword_ctr        <= '0;
          state            <= CTRL_SBOX;
        end
        CTRL_SBOX: begin
          case (sword_ctr)
            2'd0: w0 <= sbox_out;
            2'd1: w1 <= sbox_out;
            2'd2: w2 <= sbox_out;
            2'd3: w3 <= sbox_out;
            default: w0 <= sbox_out;
          endcase
          sword_ctr <= sword_ctr + 2'd1;
          if (sword_ctr == 2'd3) begin
            state <= CTRL_MAIN;
          end
        end
        CTRL_MAIN: begin
          {w0, w1, w2, w3} <= round_out;
          if (round_ctr == 4'd0) begin
            ready_reg <= 1'b1;
            state     <= CTRL_IDLE;
          end else begin
            round_ctr <= round_ctr - 4'd1;
            state     <= CTRL_SBOX;
          end
        end
        default: state <= CTRL_IDLE;
      endcase
    end
  end

endmodule : aes_decipher_round

// File: tb/tb_aes_decipher_round.sv
// Directed and random checks of aes_decipher_round against a forward-cipher
// reference built in the bench (S-box derived from GF inverse + affine map).
module tb_aes_decipher_round;

  logic         clk = 1'b0;
  logic         reset;
  logic         next;
  logic         keylen;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic [127:0] block;
  logic [127:0] new_block;
  logic         ready;

  logic [127:0] rk_mem [0:15];
  logic [7:0]   sbox_t [0:255];
  int           round_log [0:255];
  int           total = 0;
  int           bad = 0;

  typedef struct {
    logic         kl;
    logic [255:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  vec_t vecs [3];

  always #5 clk = ~clk;

  // Bench-side key memory: combinational lookup by requested round.
  assign round_key = rk_mem[round];

  aes_decipher_round dut (
    .clk       (clk),
    .reset     (reset),
    .next      (next),
    .keylen    (keylen),
    .round     (round),
    .round_key (round_key),
    .block     (block),
    .new_block (new_block),
    .ready     (ready)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] bb;
    bb = {b, b};
    return bb[15-n -: 8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, x;
    for (int v = 0; v < 256; v++) begin
      x   = v[7:0];
      inv = 8'h01;
      if (x == 8'h00) inv = 8'h00;
      else for (int k = 0; k < 254; k++) inv = gmul(inv, x);
      sbox_t[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  task automatic expand_key(input logic kl, input logic [255:0] key);
    logic [31:0] ww [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk, nr;
    nk = kl ? 8 : 4;
    nr = kl ? 14 : 10;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) ww[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = ww[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        t = subw(t);
      end
      ww[i] = ww[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) begin
      if (r <= nr) rk_mem[r] = {ww[4*r], ww[4*r+1], ww[4*r+2], ww[4*r+3]};
      else rk_mem[r] = '0;
    end
  endtask

  // Forward cipher on byte array s[row + 4*col].
  function automatic logic [127:0] encrypt(input logic kl, input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] st;
    int nr;
    nr = kl ? 14 : 10;
    st = pt ^ rk_mem[0];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_t[st[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) t[rr+4*c] = s[rr+4*((c+rr)%4)];
      if (r != nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) st[127-8*i -: 8] = t[i];
      st = st ^ rk_mem[r];
    end
    return st;
  endfunction

  // Start a run in the current cycle and wait (bounded) for ready.
  // pulse_at: edge index after which next/keylen are disturbed for one cycle.
  task automatic run(input logic kl, input logic [127:0] ct, input int pulse_at,
                     output logic [127:0] res, output int lat);
    bit done;
    next   = 1'b1;
    keylen = kl;
    block  = ct;
    @(posedge clk);
    #1;
    next = 1'b0;
    chk("ready_low_after_next", {127'b0, ready}, 128'd0);
    round_log[0] = int'(round);
    lat  = -1;
    done = 1'b0;
    for (int n = 1; n <= 200 && !done; n++) begin
      @(posedge clk);
      #1;
      if (ready) begin
        lat  = n;
        done = 1'b1;
      end else begin
        round_log[n] = int'(round);
        if (n == pulse_at) begin
          next   = 1'b1;
          keylen = ~kl;
        end else begin
          next   = 1'b0;
          keylen = kl;
        end
      end
    end
    next = 1'b0;
    res  = new_block;
  endtask

  initial begin
    logic [127:0] res;
    logic [127:0] pt, ct;
    logic [255:0] key;
    logic         kl;
    int           lat, exp_r;

    vecs[0] = '{1'b0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff};
    vecs[1] = '{1'b1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                128'h8ea2b7ca516745bfeafc49904b496089, 128'h00112233445566778899aabbccddeeff};
    vecs[2] = '{1'b0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734};

    for (int r = 0; r < 16; r++) rk_mem[r] = '0;
    build_sbox();

    reset  = 1'b1;
    next   = 1'b0;
    keylen = 1'b0;
    block  = '0;
    #3;
    chk("reset_ready", {127'b0, ready}, 128'd1);
    chk("reset_new_block", new_block, 128'd0);
    chk("reset_round", {124'b0, round}, 128'd0);
    #9;
    reset = 1'b0;
    @(posedge clk);
    #1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("idle_hold_ready", {127'b0, ready}, 128'd1);
    chk("idle_hold_round", {124'b0, round}, 128'd0);

    // Known-answer vectors, with AES-256 round-index trace.
    for (int i = 0; i < 3; i++) begin
      expand_key(vecs[i].kl, vecs[i].key);
      run(vecs[i].kl, vecs[i].ct, -1, res, lat);
      chk($sformatf("kat%0d_plaintext", i), res, vecs[i].pt);
      chk($sformatf("kat%0d_latency", i), 128'(lat), vecs[i].kl ? 128'd71 : 128'd51);
      if (vecs[i].kl) begin
        for (int n = 0; n < 71; n++) begin
          exp_r = (n == 0) ? 14 : 13 - (n - 1) / 5;
          chk($sformatf("kat%0d_round_at_%0d", i, n), 128'(round_log[n]), 128'(exp_r));
        end
      end
    end

    // Back-to-back: AES-256 run, then AES-128 started on the first ready cycle.
    expand_key(vecs[1].kl, vecs[1].key);
    run(1'b1, vecs[1].ct, -1, res, lat);
    chk("b2b_first_plaintext", res, vecs[1].pt);
    expand_key(vecs[0].kl, vecs[0].key);
    run(1'b0, vecs[0].ct, -1, res, lat);
    chk("b2b_second_plaintext", res, vecs[0].pt);
    chk("b2b_second_latency", 128'(lat), 128'd51);

    // next pulse and keylen toggle mid-run are ignored.
    run(1'b0, vecs[0].ct, 20, res, lat);
    chk("midrun_next_plaintext", res, vecs[0].pt);
    chk("midrun_next_latency", 128'(lat), 128'd51);

    // Reset during SBOX of round 5 (AES-128), then a clean run.
    next   = 1'b1;
    keylen = 1'b0;
    block  = vecs[0].ct;
    @(posedge clk);
    #1;
    next = 1'b0;
    repeat (22) begin
      @(posedge clk);
      #1;
    end
    chk("pre_reset_round", {124'b0, round}, 128'd5);
    chk("pre_reset_ready", {127'b0, ready}, 128'd0);
    reset = 1'b1;
    #1;
    chk("async_reset_ready", {127'b0, ready}, 128'd1);
    chk("async_reset_new_block", new_block, 128'd0);
    chk("async_reset_round", {124'b0, round}, 128'd0);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_reset_idle_ready", {127'b0, ready}, 128'd1);
    run(1'b0, vecs[0].ct, -1, res, lat);
    chk("post_reset_plaintext", res, vecs[0].pt);
    chk("post_reset_latency", 128'(lat), 128'd51);

    // Random keys and plaintexts, both key lengths.
    for (int i = 0; i < 1000; i++) begin
      kl  = i[0];
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      expand_key(kl, key);
      ct = encrypt(kl, pt);
      run(kl, ct, -1, res, lat);
      chk($sformatf("rand%0d_plaintext", i), res, pt);
      chk($sformatf("rand%0d_latency", i), 128'(lat), kl ? 128'd71 : 128'd51);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_aes_decipher_round
